axi4_lite_req_arbiter: RTL and testbench
========================================

# axi4_lite_req_arbiter

Shares a single `axi4_lite_master` between `NUM_REQ` independent requesters. Requests are arbitrated round-robin and issued one at a time as `START_READ`/`START_WRITE` pulses with the address and data. The block waits for the master's completion and returns the read data and response code to the granted requester. It sits between client logic (DMA, CSR bridge, debug port) and the master's start/external ports.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `ADDRESS_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `TIMEOUT_CYCLES`, default 1024: WAIT-state limit; used only when timeout is compiled in.
- `ACLK` in 1: clock, all logic on the rising edge.
- `ARESETN` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDRESS_WIDTH: flat bus; requester i occupies slice [i*AW +: AW].
- `req_wdata` in NUM_REQ*DATA_WIDTH: flat write-data bus, sliced the same way.
- `req_ready` out NUM_REQ: one-cycle one-hot grant/accept pulse.
- `resp_valid` out NUM_REQ: one-cycle one-hot completion pulse.
- `resp_rdata` out DATA_WIDTH: read data, valid with `resp_valid`.
- `resp_code` out 2: AXI response code, valid with `resp_valid`.
- `START_READ` out 1: one-cycle pulse to the master.
- `START_WRITE` out 1: one-cycle pulse to the master.
- `address` out ADDRESS_WIDTH: latched address to the master.
- `data` out DATA_WIDTH: latched write data to the master.
- `MST_DONE` in 1: master completion pulse.
- `MST_RDATA` in DATA_WIDTH: master read data, valid with `MST_DONE`.
- `MST_RESP` in 2: master RRESP/BRESP, valid with `MST_DONE`.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Latch the grant index, `req_write`, `req_addr` slice and `req_wdata` slice.
  - Next state is ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE** (exactly one cycle):
  - `req_ready[g]` = 1.
  - `START_WRITE` = latched write; `START_READ` = !latched write.
  - `rr_ptr` ← (g+1) mod NUM_REQ.
  - Next state is WAIT.
- **WAIT:**
  - On `MST_DONE`, capture `MST_RDATA` and `MST_RESP`, then go to RESP.
  - `MST_DONE` is ignored in every other state.
- **RESP** (exactly one cycle):
  - `resp_valid[g]` = 1 with `resp_rdata` and `resp_code` driven.
  - Next state is IDLE.
- **Requester contract:**
  - Hold `req_valid`, address and data stable until `req_ready` is seen.
  - Deassert or present a new request after the `req_ready` edge.
  - Because IDLE is re-entered at least 3 cycles after ISSUE, a held `req_valid` cannot be double-granted.
- **Write responses:** `resp_rdata` = 0.
- **Fairness:** every continuously-asserted requester is granted within NUM_REQ transactions.
- **Outputs:** `address`/`data` hold the last latched values until the next grant.
- **Reset values:** state IDLE, `rr_ptr` 0, and every output 0: `req_ready`, `resp_valid`, `resp_rdata`, `resp_code`, `START_*`, `address`, `data`.
- **Reset mid-transaction:** the transaction is dropped, no `resp_valid` is issued, and the FSM is in IDLE after reset release.

## Timing
- **Cycle 0:** IDLE samples `req_valid`.
- **Cycle 1:** ISSUE, with `req_ready` and `START_*` high.
- **Cycle 2 onward:** WAIT.
- **RESP:** the cycle after the `MST_DONE` cycle.
- **Back-to-back:** the earliest new grant decision is in the IDLE cycle following RESP. Minimum transaction period is 4 cycles plus master latency.
- **Registered outputs:** all outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`AXIL_ARB_TIMEOUT_EN` defined:**
  - A `$clog2(TIMEOUT_CYCLES)`-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without `MST_DONE`, go to RESP with `resp_code` = 2'b10 (SLVERR) and `resp_rdata` = 0.
  - If `MST_DONE` arrives in the same cycle as expiry, `MST_DONE` wins.
- **Undefined:** the counter is absent and WAIT waits indefinitely.

## Structure
- **Package `axil_arb_pkg`:**
  - FSM state enum (2 bits).
  - Response-code constants OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Index-width function.
- **Sub-module `rr_arbiter`:**
  - Combinational round-robin picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, grant index and any-request flag.
- **Top level:** holds the FSM, latches and timeout counter.

## Test plan
- **Reset:** assert reset with `req_valid` = 4'b1111, then release → `rr_ptr` = 0, first grant to requester 0, all outputs 0 during reset.
- **Single read:** requester 2 reads 0x1000, master returns `MST_DONE` 5 cycles after START with RDATA 0xDEADBEEF and RESP 0 → `START_READ` pulse on cycle 1 with `address` = 0x1000; `resp_valid` = 4'b0100, `resp_rdata` = 0xDEADBEEF, `resp_code` = 0.
- **Round-robin under full contention:** all 4 requesters continuously valid → grant order 0,1,2,3,0; each requester's `req_ready` is exactly one cycle wide.
- **Write with error:** requester 1 writes 0x55 to 0x20, `MST_RESP` = 2'b11 → `START_WRITE` pulse with `data` = 0x55; `resp_valid[1]` with `resp_code` = 3, `resp_rdata` = 0.
- **Timeout (`AXIL_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES = 16):** no `MST_DONE` → RESP exactly 16 cycles after WAIT entry, `resp_code` = 2'b10. Repeat with `MST_DONE` on the expiry cycle → `resp_code` equals `MST_RESP`.
- **Reset mid-WAIT:** pull `ARESETN` low during WAIT → no `resp_valid`; after release a new request is granted normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter:
// FSM state encoding, AXI response codes and an index-width helper.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of an index able to address n requesters (never less than 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_req_arbiter_rr.sv
// Combinational round-robin picker: finds the first set request bit at or
// above rr_ptr, wrapping around, and reports it as one-hot and as an index.
module rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Scan upward from the pointer; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin front end sharing one AXI4-Lite master among NUM_REQ clients.
// One transaction at a time: grant, pulse START_*, wait for MST_DONE,
// return the response to the granted client. All outputs are registered.
// Optional WAIT-state timeout is compiled in with AXIL_ARB_TIMEOUT_EN.
module axi4_lite_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic [1:0]                    resp_code,
  output logic                          START_READ,
  output logic                          START_WRITE,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic [DATA_WIDTH-1:0]         data,
  input  logic                          MST_DONE,
  input  logic [DATA_WIDTH-1:0]         MST_RDATA,
  input  logic [1:0]                    MST_RESP
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t state, next_state;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic               write_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               tmo_expired;

  logic [ADDRESS_WIDTH-1:0] addr_slice  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    wdata_slice [NUM_REQ];

  logic [NUM_REQ-1:0]    ready_d;
  logic [NUM_REQ-1:0]    resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            code_d;
  logic                  start_read_d;
  logic                  start_write_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_slice[i]  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_slice[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  // WAIT-state age counter, restarted whenever a transaction is issued.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      tmo_cnt <= '0;
    else if (state == ST_ISSUE)
      tmo_cnt <= '0;
    else if (state == ST_WAIT)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_expired = (state == ST_WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; MST_DONE only matters while waiting.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (arb_any) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (MST_DONE || tmo_expired) next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decided one cycle ahead.
  always_comb begin
    ready_d       = '0;
    resp_valid_d  = '0;
    start_read_d  = 1'b0;
    start_write_d = 1'b0;
    rdata_d       = resp_rdata;
    code_d        = resp_code;
    if (state == ST_IDLE && arb_any) begin
      ready_d       = arb_grant;
      start_write_d = req_write[arb_idx];
      start_read_d  = !req_write[arb_idx];
    end
    if (state == ST_WAIT && next_state == ST_RESP) begin
      resp_valid_d[grant_q] = 1'b1;
      if (MST_DONE) begin
        rdata_d = write_q ? '0 : MST_RDATA;
        code_d  = MST_RESP;
      end else begin
        rdata_d = '0;
        code_d  = RESP_SLVERR;
      end
    end
  end

  // Output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
      resp_code   <= RESP_OKAY;
      START_READ  <= 1'b0;
      START_WRITE <= 1'b0;
    end else begin
      req_ready   <= ready_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= rdata_d;
      resp_code   <= code_d;
      START_READ  <= start_read_d;
      START_WRITE <= start_write_d;
    end
  end

  // Request latch at grant time and pointer advance while issuing.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant_q <= '0;
      write_q <= 1'b0;
      address <= '0;
      data    <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == ST_IDLE && arb_any) begin
        grant_q <= arb_idx;
        write_q <= req_write[arb_idx];
        address <= addr_slice[arb_idx];
        data    <= wdata_slice[arb_idx];
      end
      if (state == ST_ISSUE)
        rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Self-checking bench for axi4_lite_req_arbiter: directed scenarios plus
// randomized traffic, compared every cycle against a transaction-level model.
// Timeout scenarios run when AXIL_ARB_TIMEOUT_EN is defined.
module tb_axi4_lite_req_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOUT = 16;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [1:0]      resp_code;
  logic            START_READ;
  logic            START_WRITE;
  logic [AW-1:0]   address;
  logic [DW-1:0]   data;
  logic            MST_DONE = 1'b0;
  logic [DW-1:0]   MST_RDATA = '0;
  logic [1:0]      MST_RESP = '0;

  axi4_lite_req_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
    .START_READ(START_READ), .START_WRITE(START_WRITE), .address(address), .data(data),
    .MST_DONE(MST_DONE), .MST_RDATA(MST_RDATA), .MST_RESP(MST_RESP)
  );

  always #5 ACLK = ~ACLK;

  // Requester-side stimulus
  logic          rq_v [N];
  logic          rq_w [N];
  logic [AW-1:0] rq_a [N];
  logic [DW-1:0] rq_d [N];
  logic          rst_next = 1'b0;
  bit            spur_en = 1'b0;

  // Transaction-level model
  int            cyc = 0;
  int            m_ptr = 0;
  bit            m_busy = 1'b0;
  int            m_g = 0;
  logic          m_w = 1'b0;
  logic [AW-1:0] m_a = '0, cur_a = '0;
  logic [DW-1:0] m_d = '0, cur_d = '0;
  int            issue_at = -1, done_at = -1, resp_at = -1;
  logic [DW-1:0] done_rdata = '0, exp_rdata = '0;
  logic [1:0]    done_resp = '0, exp_code = '0;
  int            m_grants[$];

  bit            use_ovr = 1'b0;
  int            ovr_lat = 1;
  logic [DW-1:0] ovr_rdata = '0;
  logic [1:0]    ovr_resp = '0;

  // Observations of the DUT (used only for directed literal checks)
  int            obs_grants[$];
  int            obs_start_cyc = 0, obs_resp_cyc = 0, obs_resp_cnt = 0;
  logic          obs_start_w = 1'b0;
  logic [AW-1:0] obs_start_addr = '0;
  logic [DW-1:0] obs_start_data = '0, obs_resp_rdata = '0;
  logic [N-1:0]  obs_resp_vec = '0;
  logic [1:0]    obs_resp_code = '0;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit modelIdle();
    return !m_busy || (cyc > resp_at);
  endfunction

  // Decide what the block must do given the inputs of the current cycle.
  task automatic modelStep();
    int lat;
    logic [DW-1:0] rd;
    logic [1:0] rc;
    if (!ARESETN) begin
      m_ptr = 0; m_busy = 1'b0; issue_at = -1; done_at = -1; resp_at = -1;
      cur_a = '0; cur_d = '0;
      return;
    end
    if (m_busy && cyc > resp_at) m_busy = 1'b0;
    if (cyc == issue_at) begin
      cur_a = m_a; cur_d = m_d; m_ptr = (m_g + 1) % N;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (rq_v[c]) begin
          m_busy = 1'b1; m_g = c; m_grants.push_back(c);
          m_w = rq_w[c]; m_a = rq_a[c]; m_d = rq_d[c];
          issue_at = cyc + 1;
          if (use_ovr) begin
            lat = ovr_lat; rd = ovr_rdata; rc = ovr_resp;
          end else begin
            lat = $urandom_range(1, 8);
`ifdef AXIL_ARB_TIMEOUT_EN
            case ($urandom_range(0, 9))
              0: lat = TOUT;
              1: lat = TOUT + 20;
              default: ;
            endcase
`endif
            rd = $urandom; rc = 2'($urandom_range(0, 3));
          end
          done_at = issue_at + lat; done_rdata = rd; done_resp = rc;
          resp_at = done_at + 1;
          exp_rdata = m_w ? '0 : rd; exp_code = rc;
`ifdef AXIL_ARB_TIMEOUT_EN
          if (lat > TOUT) begin
            done_at = -1; resp_at = issue_at + TOUT + 1;
            exp_rdata = '0; exp_code = 2'b10;
          end
`endif
          break;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare at the falling edge.
  task automatic applyStimulus();
    logic [N-1:0] e_ready, e_resp;
    bit in_wait;
    @(posedge ACLK);
    #1;
    cyc++;
    ARESETN = rst_next;
    in_wait = m_busy && (cyc > issue_at) && (cyc < resp_at);
    if (cyc == done_at) begin
      MST_DONE = 1'b1; MST_RDATA = done_rdata; MST_RESP = done_resp;
    end else if (spur_en && !in_wait && $urandom_range(0, 7) == 0) begin
      MST_DONE = 1'b1; MST_RDATA = $urandom; MST_RESP = 2'($urandom_range(0, 3));
    end else begin
      MST_DONE = 1'b0; MST_RDATA = $urandom; MST_RESP = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rq_v[i];
      req_write[i] = rq_w[i];
      req_addr[i*AW +: AW] = rq_a[i];
      req_wdata[i*DW +: DW] = rq_d[i];
    end
    modelStep();
    @(negedge ACLK);
    e_ready = '0; e_resp = '0;
    if (cyc == issue_at) e_ready[m_g] = 1'b1;
    if (cyc == resp_at)  e_resp[m_g] = 1'b1;
    checkOutput("req_ready", req_ready, e_ready);
    checkOutput("START_READ", START_READ, (cyc == issue_at) && !m_w);
    checkOutput("START_WRITE", START_WRITE, (cyc == issue_at) && m_w);
    checkOutput("resp_valid", resp_valid, e_resp);
    checkOutput("address", address, cur_a);
    checkOutput("data", data, cur_d);
    if (cyc == resp_at) begin
      checkOutput("resp_rdata", resp_rdata, exp_rdata);
      checkOutput("resp_code", resp_code, exp_code);
    end
    if (!ARESETN) begin
      checkOutput("reset_rdata", resp_rdata, '0);
      checkOutput("reset_code", resp_code, '0);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin obs_grants.push_back(i); break; end
    if (START_READ || START_WRITE) begin
      obs_start_cyc = cyc; obs_start_w = START_WRITE;
      obs_start_addr = address; obs_start_data = data;
    end
    if (|resp_valid) begin
      obs_resp_cnt++; obs_resp_cyc = cyc; obs_resp_vec = resp_valid;
      obs_resp_rdata = resp_rdata; obs_resp_code = resp_code;
    end
  endtask

  // Requester behaviour right after a grant edge, plus random new requests.
  task automatic serviceRequesters(input int mode);
    if (ARESETN && cyc == issue_at) begin
      case (mode)
        0: rq_v[m_g] = 1'b0;
        1: begin rq_a[m_g] = rq_a[m_g] + 4; rq_d[m_g] = $urandom; end
        default: begin
          rq_v[m_g] = $urandom_range(0, 1) == 1;
          rq_w[m_g] = $urandom_range(0, 1) == 1;
          rq_a[m_g] = $urandom; rq_d[m_g] = $urandom;
        end
      endcase
    end
    if (mode == 2)
      for (int i = 0; i < N; i++)
        if (!rq_v[i] && $urandom_range(0, 4) == 0) begin
          rq_v[i] = 1'b1; rq_w[i] = $urandom_range(0, 1) == 1;
          rq_a[i] = $urandom; rq_d[i] = $urandom;
        end
  endtask

  task automatic runCycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      serviceRequesters(mode);
      applyStimulus();
    end
  endtask

  task automatic waitGrants(input int target, input int mode);
    int budget;
    budget = 200;
    while (obs_grants.size() < target && budget > 0) begin
      serviceRequesters(mode); applyStimulus(); budget--;
    end
    if (obs_grants.size() < target) checkOutput("grant_wait_expired", obs_grants.size(), target);
  endtask

  task automatic waitResp(input int prev_cnt);
    int budget;
    budget = 200;
    while (obs_resp_cnt <= prev_cnt && budget > 0) begin
      serviceRequesters(0); applyStimulus(); budget--;
    end
    if (obs_resp_cnt <= prev_cnt) checkOutput("resp_wait_expired", obs_resp_cnt, prev_cnt + 1);
  endtask

  task automatic waitIdle();
    int budget;
    bit any;
    budget = 200;
    any = 1'b1;
    while (budget > 0 && (any || !modelIdle())) begin
      serviceRequesters(0); applyStimulus(); budget--;
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= rq_v[i];
    end
    if (any || !modelIdle()) checkOutput("idle_wait_expired", 0, 1);
  endtask

  task automatic setReq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_v[i] = 1'b1; rq_w[i] = w; rq_a[i] = a; rq_d[i] = d;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gb, n_resp, req_cyc;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'(i * 256), '0);

    // Reset with every requester asking; pointer must restart at 0.
    rst_next = 1'b0;
    runCycles(3, 0);
    checkOutput("reset_ready_zero", req_ready, '0);
    checkOutput("reset_addr_zero", address, '0);
    rst_next = 1'b1;
    use_ovr = 1'b1; ovr_lat = 2; ovr_rdata = 32'h1234; ovr_resp = 2'b00;
    gb = obs_grants.size();
    waitGrants(gb + 4, 0);
    checkOutput("first_grant_after_reset", obs_grants[gb], 0);
    checkOutput("model_first_grant", m_grants[0], 0);
    waitIdle();

    // Full contention: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'(32'h4000 + i * 16), '0);
    gb = obs_grants.size();
    waitGrants(gb + 5, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_order", obs_grants[gb + k], exp_order[k]);
      checkOutput("model_rr_order", m_grants[m_grants.size() - 5 + k], exp_order[k]);
    end
    for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    waitIdle();

    // Single read by requester 2.
    ovr_lat = 5; ovr_rdata = 32'hDEADBEEF; ovr_resp = 2'b00;
    setReq(2, 1'b0, 32'h1000, '0);
    req_cyc = cyc + 1;
    n_resp = obs_resp_cnt;
    waitResp(n_resp);
    checkOutput("read_start_delay", obs_start_cyc - req_cyc, 1);
    checkOutput("read_start_is_read", obs_start_w, 1'b0);
    checkOutput("read_address", obs_start_addr, 32'h1000);
    checkOutput("read_resp_vec", obs_resp_vec, 4'b0100);
    checkOutput("read_rdata", obs_resp_rdata, 32'hDEADBEEF);
    checkOutput("read_code", obs_resp_code, 2'b00);
    checkOutput("read_resp_delay", obs_resp_cyc - obs_start_cyc, 6);
    checkOutput("model_read_delay", resp_at - issue_at, 6);
    waitIdle();

    // Write from requester 1 with DECERR.
    ovr_lat = 3; ovr_rdata = 32'hFFFFFFFF; ovr_resp = 2'b11;
    setReq(1, 1'b1, 32'h20, 32'h55);
    n_resp = obs_resp_cnt;
    waitResp(n_resp);
    checkOutput("write_start_is_write", obs_start_w, 1'b1);
    checkOutput("write_data", obs_start_data, 32'h55);
    checkOutput("write_address", obs_start_addr, 32'h20);
    checkOutput("write_resp_vec", obs_resp_vec, 4'b0010);
    checkOutput("write_code", obs_resp_code, 2'b11);
    checkOutput("write_rdata", obs_resp_rdata, '0);
    checkOutput("model_write_rdata", exp_rdata, '0);
    waitIdle();

    // Reset while waiting for the master: no response, normal afterwards.
    ovr_lat = 10; ovr_rdata = 32'hCAFE; ovr_resp = 2'b00;
    setReq(0, 1'b0, 32'h40, '0);
    gb = obs_grants.size();
    waitGrants(gb + 1, 0);
    runCycles(2, 0);
    n_resp = obs_resp_cnt;
    rst_next = 1'b0;
    runCycles(2, 0);
    rst_next = 1'b1;
    runCycles(15, 0);
    checkOutput("no_resp_after_reset", obs_resp_cnt - n_resp, 0);
    ovr_lat = 2; ovr_rdata = 32'h0BAD; ovr_resp = 2'b01;
    setReq(3, 1'b0, 32'h80, '0);
    n_resp = obs_resp_cnt;
    waitResp(n_resp);
    checkOutput("post_reset_grant", obs_grants[obs_grants.size() - 1], 3);
    checkOutput("post_reset_resp_vec", obs_resp_vec, 4'b1000);
    checkOutput("post_reset_code", obs_resp_code, 2'b01);
    waitIdle();

`ifdef AXIL_ARB_TIMEOUT_EN
    // Master never answers: SLVERR 16 cycles after WAIT entry.
    ovr_lat = 100; ovr_rdata = 32'h7777; ovr_resp = 2'b00;
    setReq(1, 1'b0, 32'h30, '0);
    n_resp = obs_resp_cnt;
    waitResp(n_resp);
    checkOutput("timeout_code", obs_resp_code, 2'b10);
    checkOutput("timeout_rdata", obs_resp_rdata, '0);
    checkOutput("timeout_delay", obs_resp_cyc - obs_start_cyc, 17);
    waitIdle();
    // MST_DONE on the expiry cycle wins.
    ovr_lat = 16; ovr_rdata = 32'hABCD; ovr_resp = 2'b01;
    setReq(1, 1'b0, 32'h34, '0);
    n_resp = obs_resp_cnt;
    waitResp(n_resp);
    checkOutput("expiry_done_code", obs_resp_code, 2'b01);
    checkOutput("expiry_done_rdata", obs_resp_rdata, 32'hABCD);
    checkOutput("expiry_done_delay", obs_resp_cyc - obs_start_cyc, 17);
    waitIdle();
`endif

    // Randomized traffic with spurious master pulses outside WAIT.
    use_ovr = 1'b0;
    spur_en = 1'b1;
    runCycles(800, 2);
    for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
